set_job_ctrl: RTL and testbench

- Host-side controller for the SET circle-set counting engine: the initiator end of SET's en/central/radius/mode → valid/candidate interface.
- Buffers incoming jobs in a small FIFO, issues them to SET one at a time, waits for the SET valid pulse and captures the candidate count.
- Returns each result, tagged, through a ready/valid output port. Detects hung jobs with a timeout.

---
 rtl/set_job_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_set_job_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : set_job_ctrl
// Brief    : Host-side job controller for the SET circle-set counting engine.
//            Queues jobs, issues them one at a time, collects tagged results.
//            Optional statistics counters are enabled with SET_STATS_EN.
// Revision : 1.0
// ============================================================================
module set_job_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 96,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_timeout,
`ifdef SET_STATS_EN
    output logic [15:0]      stat_jobs,
    output logic [7:0]       stat_timeouts,
    output logic [7:0]       stat_max_cand,
`endif
    output logic             idle
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = 38;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [23:0]        set_central_q, set_central_d;
    logic [11:0]        set_radius_q, set_radius_d;
    logic [1:0]         set_mode_q, set_mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               res_valid_q, res_valid_d;
    logic [7:0]         res_candidate_q, res_candidate_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic               res_timeout_q, res_timeout_d;

    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    logic [ENTRY_W-1:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign push  = job_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    // Job FIFO: storage needs no reset, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {job_central, job_radius, job_mode};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        pop             = 1'b0;
        set_central_d   = set_central_q;
        set_radius_d    = set_radius_q;
        set_mode_d      = set_mode_q;
        cnt_d           = cnt_q;
        tag_d           = tag_q;
        res_valid_d     = res_valid_q;
        res_candidate_d = res_candidate_q;
        res_tag_d       = res_tag_q;
        res_timeout_d   = res_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    set_central_d = head[37:14];
                    set_radius_d  = head[13:2];
                    set_mode_d    = head[1:0];
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result strobe beats the timeout when both land together.
                if (set_valid) begin
                    res_candidate_d = set_candidate;
                    res_timeout_d   = 1'b0;
                    res_tag_d       = tag_q;
                    tag_d           = tag_q + TAG_W'(1);
                    state_d         = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    res_candidate_d = 8'd0;
                    res_timeout_d   = 1'b1;
                    res_tag_d       = tag_q;
                    tag_d           = tag_q + TAG_W'(1);
                    state_d         = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // Keeps set_en away from the cycle SET still drives valid.
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            set_central_q   <= '0;
            set_radius_q    <= '0;
            set_mode_q      <= '0;
            cnt_q           <= '0;
            tag_q           <= '0;
            res_valid_q     <= 1'b0;
            res_candidate_q <= '0;
            res_tag_q       <= '0;
            res_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            set_central_q   <= set_central_d;
            set_radius_q    <= set_radius_d;
            set_mode_q      <= set_mode_d;
            cnt_q           <= cnt_d;
            tag_q           <= tag_d;
            res_valid_q     <= res_valid_d;
            res_candidate_q <= res_candidate_d;
            res_tag_q       <= res_tag_d;
            res_timeout_q   <= res_timeout_d;
        end
    end

    assign job_ready     = !full;
    assign set_en        = (state_q == ST_ISSUE);
    assign set_central   = set_central_q;
    assign set_radius    = set_radius_q;
    assign set_mode      = set_mode_q;
    assign res_valid     = res_valid_q;
    assign res_candidate = res_candidate_q;
    assign res_tag       = res_tag_q;
    assign res_timeout   = res_timeout_q;
    assign idle          = (state_q == ST_IDLE) && empty;

`ifdef SET_STATS_EN
    logic        handoff;
    logic [15:0] stat_jobs_q, stat_jobs_d;
    logic [7:0]  stat_timeouts_q, stat_timeouts_d;
    logic [7:0]  stat_max_cand_q, stat_max_cand_d;

    assign handoff = res_valid_q && res_ready;

    always_comb begin
        stat_jobs_d     = stat_jobs_q;
        stat_timeouts_d = stat_timeouts_q;
        stat_max_cand_d = stat_max_cand_q;
        if (handoff) begin
            if (stat_jobs_q != 16'hFFFF) begin
                stat_jobs_d = stat_jobs_q + 16'd1;
            end
            if (res_timeout_q && (stat_timeouts_q != 8'hFF)) begin
                stat_timeouts_d = stat_timeouts_q + 8'd1;
            end
            if (res_candidate_q > stat_max_cand_q) begin
                stat_max_cand_d = res_candidate_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_jobs_q     <= '0;
            stat_timeouts_q <= '0;
            stat_max_cand_q <= '0;
        end else begin
            stat_jobs_q     <= stat_jobs_d;
            stat_timeouts_q <= stat_timeouts_d;
            stat_max_cand_q <= stat_max_cand_d;
        end
    end

    assign stat_jobs     = stat_jobs_q;
    assign stat_timeouts = stat_timeouts_q;
    assign stat_max_cand = stat_max_cand_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_job_ctrl
// Brief    : Directed self-checking bench for set_job_ctrl with a SET model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_set_job_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [23:0] job_central;
    logic [11:0] job_radius;
    logic [1:0]  job_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_candidate;
    logic [3:0]  res_tag;
    logic        res_timeout;
    logic        idle;

    set_job_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(96), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_valid(set_valid), .set_candidate(set_candidate),
        .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
        .res_tag(res_tag), .res_timeout(res_timeout), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SET model response script: one latency/candidate pair per issued job.
    int          lat_q[$];
    logic [7:0]  mcand_q[$];
    // Observations.
    int          en_count = 0;
    int          en_cyc   = 0;
    int          coincide = 0;
    logic [23:0] en_central;
    logic [11:0] en_radius;
    logic [7:0]  r_cand[$];
    logic [3:0]  r_tag[$];
    logic        r_to[$];
    int          r_cyc[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    initial begin
        set_valid = 1'b0;
        set_candidate = 8'd0;
        forever begin
            @(negedge clk);
            if (set_en && lat_q.size() > 0) begin
                int         l;
                logic [7:0] c;
                l = lat_q.pop_front();
                c = mcand_q.pop_front();
                repeat (l) @(posedge clk);
                #1;
                set_valid = 1'b1;
                set_candidate = c;
                @(posedge clk);
                #1;
                set_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (set_en) begin
                en_count++;
                en_cyc = cyc;
                en_central = set_central;
                en_radius = set_radius;
            end
            if (set_en && set_valid) coincide++;
            if (res_valid && res_ready) begin
                r_cand.push_back(res_candidate);
                r_tag.push_back(res_tag);
                r_to.push_back(res_timeout);
                r_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        job_valid = 1'b0;
        lat_q.delete();
        mcand_q.delete();
        r_cand.delete();
        r_tag.delete();
        r_to.delete();
        r_cyc.delete();
        en_count = 0;
        coincide = 0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n = 0;
        job_central = c;
        job_radius = r;
        job_mode = m;
        job_valid = 1'b1;
        while (!job_ready && n < 400) begin
            step(1);
            n++;
        end
        if (n >= 400) check("push_bound", 32'd0, 32'd1);
        step(1);
        job_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int bound);
        int k = 0;
        while (r_cand.size() < n && k < bound) begin
            step(1);
            k++;
        end
        check("result_count", r_cand.size(), n);
    endtask

    task automatic wait_res_valid(input int bound);
        int k = 0;
        while (!res_valid && k < bound) begin
            step(1);
            k++;
        end
        check("res_valid_seen", res_valid, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        job_valid = 1'b0;
        job_central = '0;
        job_radius = '0;
        job_mode = '0;
        res_ready = 1'b1;
        #2;
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_set_en", set_en, 1'b0);
        check("rst_set_central", set_central, 24'd0);
        check("rst_set_radius", set_radius, 12'd0);
        check("rst_set_mode", set_mode, 2'd0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_candidate", res_candidate, 8'd0);
        check("rst_res_tag", res_tag, 4'd0);
        check("rst_res_timeout", res_timeout, 1'b0);
        check("rst_idle", idle, 1'b1);

        // Single nominal job.
        do_reset();
        lat_q.push_back(66); mcand_q.push_back(8'd29);
        push_job(24'h442666, 12'h300, 2'd0);
        wait_results(1, 300);
        check("t1_cand", r_cand[0], 8'd29);
        check("t1_tag", r_tag[0], 4'd0);
        check("t1_timeout", r_to[0], 1'b0);
        check("t1_en_count", en_count, 1);
        check("t1_central", en_central, 24'h442666);
        check("t1_radius", en_radius, 12'h300);
        check("t1_latency", r_cyc[0] - en_cyc, 68);
        check("t1_valid_drop", res_valid, 1'b0);
        check("t1_idle", idle, 1'b1);

        // Five back-to-back jobs into a depth-4 FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            lat_q.push_back(66);
            mcand_q.push_back(8'(10 + i));
        end
        for (int i = 0; i < 5; i++) push_job(24'(i), 12'(i), 2'(i));
        check("t2_full_ready", job_ready, 1'b0);
        check("t2_not_idle", idle, 1'b0);
        begin
            int k = 0;
            while (!job_ready && k < 300) begin
                step(1);
                k++;
            end
        end
        check("t2_ready_after_pop", r_cand.size(), 1);
        wait_results(5, 600);
        for (int i = 0; i < 5; i++) begin
            check("t2_tag", r_tag[i], 4'(i));
            check("t2_cand", r_cand[i], 8'(10 + i));
            check("t2_timeout", r_to[i], 1'b0);
        end
        check("t2_en_count", en_count, 5);
        check("t2_no_coincide", coincide, 0);

        // Timeout with a late strobe, then a normal job.
        do_reset();
        res_ready = 1'b0;
        lat_q.push_back(100); mcand_q.push_back(8'd77);
        lat_q.push_back(66);  mcand_q.push_back(8'd33);
        push_job(24'h123456, 12'h111, 2'd1);
        push_job(24'h654321, 12'h222, 2'd2);
        wait_res_valid(300);
        check("t3_to_latency", cyc - en_cyc, 98);
        step(5);
        check("t3_hold_valid", res_valid, 1'b1);
        check("t3_timeout", res_timeout, 1'b1);
        check("t3_cand_zero", res_candidate, 8'd0);
        check("t3_tag", res_tag, 4'd0);
        res_ready = 1'b1;
        wait_results(2, 300);
        check("t3_next_cand", r_cand[1], 8'd33);
        check("t3_next_tag", r_tag[1], 4'd1);
        check("t3_next_timeout", r_to[1], 1'b0);
        check("t3_en_count", en_count, 2);

        // Backpressure: result must hold, no new issue.
        do_reset();
        res_ready = 1'b0;
        lat_q.push_back(66); mcand_q.push_back(8'd5);
        lat_q.push_back(66); mcand_q.push_back(8'd6);
        push_job(24'hAAAAAA, 12'h555, 2'd3);
        push_job(24'hBBBBBB, 12'h666, 2'd0);
        wait_res_valid(300);
        begin
            int unstable = 0;
            for (int i = 0; i < 20; i++) begin
                if (!res_valid || res_candidate !== 8'd5 || res_tag !== 4'd0 || res_timeout !== 1'b0)
                    unstable++;
                step(1);
            end
            check("t4_stable", unstable, 0);
        end
        check("t4_no_issue", en_count, 1);
        res_ready = 1'b1;
        begin
            int k = 0;
            while (en_count < 2 && k < 20) begin
                step(1);
                k++;
            end
        end
        check("t4_issue_gap", en_cyc - r_cyc[0], 2);
        wait_results(2, 300);
        check("t4_cand2", r_cand[1], 8'd6);
        check("t4_tag2", r_tag[1], 4'd1);

        // Strobe and timeout on the same cycle.
        do_reset();
        lat_q.push_back(96); mcand_q.push_back(8'd55);
        push_job(24'h010203, 12'h456, 2'd1);
        wait_results(1, 300);
        check("t5_cand", r_cand[0], 8'd55);
        check("t5_timeout", r_to[0], 1'b0);
        check("t5_tag", r_tag[0], 4'd0);

        // Reset during WAIT with three jobs queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lat_q.push_back(66);
            mcand_q.push_back(8'd9);
        end
        for (int i = 0; i < 4; i++) push_job(24'hFFFFFF, 12'hFFF, 2'd3);
        step(20);
        check("t6_busy", idle, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_job_ready", job_ready, 1'b1);
        check("t6_set_en", set_en, 1'b0);
        check("t6_set_central", set_central, 24'd0);
        check("t6_res_valid", res_valid, 1'b0);
        check("t6_res_tag", res_tag, 4'd0);
        check("t6_idle", idle, 1'b1);
        en_count = 0;
        r_cand.delete();
        step(2);
        rst = 1'b0;
        step(150);
        check("t6_no_results", r_cand.size(), 0);
        check("t6_no_issue", en_count, 0);
        check("t6_idle_after", idle, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
